// File: rtl/legv8_pkg.sv
// Shared constants for the LEGv8 multi-cycle controller: opcodes, FSM state
// encodings, ALU operation classes and instruction classes.
package legv8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_RTYPE   = 3'd1,
    CL_LDUR    = 3'd2,
    CL_STUR    = 3'd3,
    CL_B       = 3'd4,
    CL_CBZ     = 3'd5
  } iclass_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  typedef struct packed {
    logic       reg2loc;
    logic       alusrc;
    logic       mem2reg;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t class_ctrl(input iclass_t c);
    ctrl_t r;
    r = '0;
    case (c)
      CL_LDUR:  begin r.alusrc = 1'b1; r.mem2reg = 1'b1; r.alu_op = ALUOP_ADD; end
      CL_STUR:  begin r.reg2loc = 1'b1; r.alusrc = 1'b1; r.alu_op = ALUOP_ADD; end
      CL_RTYPE: r.alu_op = ALUOP_RTYPE;
      CL_B,
      CL_CBZ:   begin r.reg2loc = 1'b1; r.alu_op = ALUOP_PASSB; end
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/legv8_decode.sv
// Combinational instruction classifier: maps an instruction word to its class
// and the static datapath control bits for that class.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     iclass,
  output ctrl_t       ctrl
);

  // Only the opcode field matters here; the operand fields are the datapath's.
  logic unused_bits;
  assign unused_bits = ^ir[20:0];

  always_comb begin
    iclass = CL_ILLEGAL;
    // Branch encodings are shorter and must win over the 11-bit opcode match.
    if (ir[31:26] == OP_B) begin
      iclass = CL_B;
    end else if (ir[31:24] == OP_CBZ) begin
      iclass = CL_CBZ;
    end else begin
      case (ir[31:21])
        OP_LDUR: iclass = CL_LDUR;
        OP_STUR: iclass = CL_STUR;
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_ORR:  iclass = CL_RTYPE;
        default: iclass = CL_ILLEGAL;
      endcase
    end
    ctrl = class_ctrl(iclass);
  end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: owns PC and IR, arbitrates one memory port
// between fetch and LDUR/STUR, and drives registered datapath controls.
module legv8_multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic [31:0]         MEM_RDATA,
  input  logic                MEM_ACK,
  input  logic                ALU_ZERO,
  input  logic [PC_WIDTH-1:0] BR_TARGET,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic                MEM_SEL_DATA,
  output logic [31:0]         IR,
  output logic [PC_WIDTH-1:0] PC,
  output logic                REG2LOC,
  output logic                ALUSRC,
  output logic                MEM2REG,
  output logic                REGWRITE,
  output logic [1:0]          ALU_OP,
  output logic                RETIRED,
  output logic                ILLEGAL,
  output logic [2:0]          STATE
);

  state_t              state_reg, state_next;
  iclass_t             class_reg;
  ctrl_t               ctrl_reg;
  logic [31:0]         ir_reg;
  logic [PC_WIDTH-1:0] pc_reg, pc_next, pc_plus4;
  logic                retire_next;
  logic                mem_req_reg, mem_we_reg, mem_sel_reg;
  logic                regwrite_reg, retired_reg, illegal_reg;

  iclass_t             dec_class;
  ctrl_t               dec_ctrl;

  // Classify the word arriving on the bus so class and controls land in the
  // same edge as IR and are already valid during DECODE.
  legv8_decode u_decode (
    .ir     (MEM_RDATA),
    .iclass (dec_class),
    .ctrl   (dec_ctrl)
  );

  assign pc_plus4 = pc_reg + PC_WIDTH'(4);

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    retire_next = 1'b0;
    case (state_reg)
      ST_IDLE:   state_next = ST_FETCH;
      ST_FETCH:  if (MEM_ACK) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        case (class_reg)
          CL_RTYPE: state_next = ST_WB;
          CL_LDUR,
          CL_STUR:  state_next = ST_MEM;
          CL_B: begin
            pc_next     = BR_TARGET;
            retire_next = 1'b1;
            state_next  = ST_FETCH;
          end
          CL_CBZ: begin
            pc_next     = ALU_ZERO ? BR_TARGET : pc_plus4;
            retire_next = 1'b1;
            state_next  = ST_FETCH;
          end
          default: begin
            pc_next     = pc_plus4;
            retire_next = 1'b1;
            state_next  = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        if (MEM_ACK) begin
          if (class_reg == CL_STUR) begin
            pc_next     = pc_plus4;
            retire_next = 1'b1;
            state_next  = ST_FETCH;
          end else begin
            state_next  = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_next     = pc_plus4;
        retire_next = 1'b1;
        state_next  = ST_FETCH;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so none of them can
  // follow MEM_ACK combinationally.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      class_reg    <= CL_ILLEGAL;
      ctrl_reg     <= '0;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      mem_sel_reg  <= 1'b0;
      regwrite_reg <= 1'b0;
      retired_reg  <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retire_next;
      if (state_reg == ST_FETCH && MEM_ACK) begin
        ir_reg    <= MEM_RDATA;
        class_reg <= dec_class;
        ctrl_reg  <= dec_ctrl;
      end
      mem_req_reg  <= (state_next == ST_FETCH) || (state_next == ST_MEM);
      mem_sel_reg  <= (state_next == ST_MEM);
      mem_we_reg   <= (state_next == ST_MEM) && (class_reg == CL_STUR);
      regwrite_reg <= (state_next == ST_WB);
      illegal_reg  <= (state_next == ST_EXEC) && (class_reg == CL_ILLEGAL);
    end
  end

  assign STATE        = state_reg;
  assign PC           = pc_reg;
  assign IR           = ir_reg;
  assign MEM_REQ      = mem_req_reg;
  assign MEM_WE       = mem_we_reg;
  assign MEM_SEL_DATA = mem_sel_reg;
  assign REGWRITE     = regwrite_reg;
  assign RETIRED      = retired_reg;
  assign ILLEGAL      = illegal_reg;
  assign REG2LOC      = ctrl_reg.reg2loc;
  assign ALUSRC       = ctrl_reg.alusrc;
  assign MEM2REG      = ctrl_reg.mem2reg;
  assign ALU_OP       = ctrl_reg.alu_op;

endmodule
